// File: rtl/fifo_rd_packer.sv
// Purpose: pops entries from the async FIFO read port and packs PACK_RATIO lanes into one wide word.
// Latency: rd_en in cycle N lands at the end of N+1; a full word is valid PACK_RATIO+1 cycles after its first read.
// Backpressure: out_valid/out_ready; one extra word is held in the pack register, then reads stop.
//
// Ports:
//   RClk, PresetFull            read clock, async active-high reset
//   fifo_empty/fifo_rd_en       FIFO read handshake (rd_en combinational)
//   fifo_data                   FIFO entry, valid the cycle after rd_en
//   flush                       pulse: emit a partial word with lane keep mask
//   out_data/out_keep/out_valid packed word stream, lane 0 = oldest entry
//   out_ready                   downstream accept
//   word_count                  words accepted downstream (wraps)
//   busy                        pack non-empty, read in flight or flush pending
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             RClk,
  input  logic                             PresetFull,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_WIDTH-1:0]             word_count,
  output logic                             busy
);

  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam int FW = $clog2(PACK_RATIO + 1);

  localparam logic [FW-1:0]        FILL_ONE  = FW'(1);
  localparam logic [FW-1:0]        FILL_FULL = FW'(PACK_RATIO);
  localparam logic [FW:0]          PEND_FULL = (FW+1)'(PACK_RATIO);
  localparam logic [FW:0]          PEND_LAST = (FW+1)'(PACK_RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_FILL, S_LAST, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   inflight_q, inflight_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [WW-1:0]          pack_q, pack_d;
  logic [WW-1:0]          out_data_q, out_data_d;
  logic [PACK_RATIO-1:0]  out_keep_q, out_keep_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;

  logic                   out_free;
  logic                   accept;
  logic [FW:0]            pending;

  // Output register can take a new word this cycle (empty or draining now).
  assign out_free = !out_valid_q || out_ready;
  assign accept   = out_valid_q && out_ready;
  // Lanes already landed plus the one on its way back from the FIFO.
  assign pending  = {1'b0, fill_q} + {{FW{1'b0}}, inflight_q};

  always_comb begin
    fifo_rd_en = 1'b0;
    if (!PresetFull && !fifo_empty && !flush_pend_q) begin
      case (state_q)
        S_FILL:  fifo_rd_en = (pending < PEND_FULL);
        // Overlapping read for the next word only when the current word is
        // guaranteed to leave the pack register as its last lane lands.
        S_LAST:  fifo_rd_en = out_free;
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    inflight_d   = fifo_rd_en;
    flush_pend_d = flush_pend_q || flush;
    pack_d       = pack_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q && !out_ready;
    word_count_d = accept ? (word_count_q + CNT_ONE) : word_count_q;

    // Returning entry lands in lane fill_q; harmless when the same cycle
    // transfers the pack, since fill restarts at lane 0.
    if (inflight_q) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (fill_q == FW'(i)) pack_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
    end

    case (state_q)
      S_FILL: begin
        if (inflight_q) fill_d = fill_q + FILL_ONE;
        if (fifo_rd_en && (pending == PEND_LAST)) state_d = S_LAST;
        // Flush waits for any in-flight lane so it is included in the word.
        if (flush_pend_q && !inflight_q) begin
          if (fill_q == '0) begin
            flush_pend_d = 1'b0;
          end else if (out_free) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
              if (FW'(i) < fill_q) begin
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i*DATA_WIDTH +: DATA_WIDTH];
                out_keep_d[i] = 1'b1;
              end else begin
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                out_keep_d[i] = 1'b0;
              end
            end
            out_valid_d  = 1'b1;
            fill_d       = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      S_LAST: begin
        // The final lane is landing now; forward it straight into the word.
        if (out_free) begin
          out_data_d   = {fifo_data, pack_q[WW-DATA_WIDTH-1:0]};
          out_keep_d   = '1;
          out_valid_d  = 1'b1;
          fill_d       = '0;
          flush_pend_d = 1'b0;
          state_d      = S_FILL;
        end else begin
          fill_d  = FILL_FULL;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_free) begin
          out_data_d   = pack_q;
          out_keep_d   = '1;
          out_valid_d  = 1'b1;
          fill_d       = '0;
          flush_pend_d = 1'b0;
          state_d      = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      state_q      <= S_FILL;
      fill_q       <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      pack_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      pack_q       <= pack_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;
  assign busy       = (fill_q != '0) || inflight_q || flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Purpose: directed + randomized bench for fifo_rd_packer with an in-bench stream model.
// Latency: model groups entries by the cycle their read was issued; outputs checked every negedge.
// Backpressure: out_ready driven by the tests; held-word stability checked while stalled.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PR = 4;
  localparam int CW = 16;

  logic            RClk = 1'b0;
  logic            PresetFull = 1'b1;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_data = '0;
  logic            flush = 1'b0;
  logic [DW*PR-1:0] out_data;
  logic [PR-1:0]   out_keep;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CW-1:0]   word_count;
  logic            busy;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)) dut (
    .RClk(RClk), .PresetFull(PresetFull), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count), .busy(busy)
  );

  always #5 RClk = ~RClk;

  typedef struct packed {
    logic [DW*PR-1:0] d;
    logic [PR-1:0]    k;
  } word_t;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] fifo_mem[$];
  logic          empty_gate = 1'b0;
  logic          rd_s = 1'b0;
  int            cyc = 0;

  logic [DW-1:0] cur[$];
  word_t         exp_q[$];
  word_t         acc_log[$];
  int            rd_log[$];
  int            valid_rise[$];
  int            model_cnt = 0;
  logic          prev_stall = 1'b0;
  logic          prev_valid = 1'b0;
  word_t         prev_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // FIFO model: pops on the edge after a sampled read enable.
  always @(posedge RClk) begin
    cyc <= cyc + 1;
    if (rd_s && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
  end

  // Stream model and per-cycle compare.
  always @(negedge RClk) begin
    word_t w;
    rd_s = fifo_rd_en;
    if (PresetFull) begin
      check("rd_en_in_reset", {63'd0, fifo_rd_en}, 64'd0);
      cur.delete();
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("rd_while_empty", {63'd0, fifo_rd_en & fifo_empty}, 64'd0);
      if (fifo_rd_en) begin
        rd_log.push_back(cyc);
        if (fifo_mem.size() > 0) cur.push_back(fifo_mem[0]);
        if (cur.size() == PR) begin
          w.k = '1;
          for (int i = 0; i < PR; i++) w.d[i*DW +: DW] = cur[i];
          exp_q.push_back(w);
          cur.delete();
        end
      end
      if (flush && cur.size() > 0) begin
        w.d = '0;
        w.k = '0;
        for (int i = 0; i < cur.size(); i++) begin
          w.d[i*DW +: DW] = cur[i];
          w.k[i] = 1'b1;
        end
        exp_q.push_back(w);
        cur.delete();
      end
      if (prev_stall) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_hold", 64'({out_data, out_keep}), 64'(prev_word));
      end
      check("word_count", 64'(word_count), 64'(model_cnt % 65536));
      if (out_valid && !prev_valid) valid_rise.push_back(cyc);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_word: got %0h keep %0h, expected no word", out_data, out_keep);
        end else begin
          w = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(w.d));
          check("word_keep", 64'(out_keep), 64'(w.k));
        end
        acc_log.push_back({out_data, out_keep});
        model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_word  = {out_data, out_keep};
    end
  end

  task automatic step();
    @(posedge RClk);
    #1;
    flush = 1'b0;
    fifo_empty = (fifo_mem.size() == 0) || empty_gate;
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem.push_back(v);
    fifo_empty = empty_gate;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    out_ready  = 1'b1;
    empty_gate = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (fifo_mem.size() == 0 && exp_q.size() == 0 && !busy && !out_valid) done = 1;
      else step();
    end
    if (!done) begin
      total++;
      $display("FAIL %s: drain timeout, busy=%0d out_valid=%0d pending_words=%0d", name, busy, out_valid, exp_q.size());
    end
  endtask

  initial begin
    int r0, a0, v0, n, pushed;
    word_t w;

    // Reset state, with data already waiting in the FIFO.
    for (int v = 1; v <= 8; v++) push(8'(v));
    step();
    step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    // Test 1: two back-to-back full words.
    r0 = rd_log.size(); a0 = acc_log.size(); v0 = valid_rise.size();
    PresetFull = 1'b0;
    repeat (12) step();
    w = acc_log[a0];
    check("t1_w0_data", 64'(w.d), 64'h04030201);
    check("t1_w0_keep", 64'(w.k), 64'hF);
    w = acc_log[a0+1];
    check("t1_w1_data", 64'(w.d), 64'h08070605);
    check("t1_w1_keep", 64'(w.k), 64'hF);
    check("t1_word_count", 64'(word_count), 64'd2);
    check("t1_rd_count", 64'(rd_log.size() - r0), 64'd8);
    check("t1_rd_span", 64'(rd_log[r0+7] - rd_log[r0]), 64'd7);
    check("t1_latency", 64'(valid_rise[v0] - rd_log[r0]), 64'(PR + 1));

    // Test 2: backpressure buffers exactly two words.
    out_ready = 1'b0;
    r0 = rd_log.size(); a0 = acc_log.size();
    for (int v = 16; v < 28; v++) push(8'(v));
    repeat (20) step();
    check("t2_valid_held", {63'd0, out_valid}, 64'd1);
    check("t2_held_data", 64'(out_data), 64'h13121110);
    check("t2_rd_count", 64'(rd_log.size() - r0), 64'd8);
    check("t2_rd_stopped", {63'd0, fifo_rd_en}, 64'd0);
    check("t2_fifo_left", 64'(fifo_mem.size()), 64'd4);
    check("t2_busy", {63'd0, busy}, 64'd1);
    wait_idle("t2_drain", 200);
    check("t2_words", 64'(acc_log.size() - a0), 64'd3);
    w = acc_log[a0];   check("t2_w0", 64'(w.d), 64'h13121110);
    w = acc_log[a0+1]; check("t2_w1", 64'(w.d), 64'h17161514);
    w = acc_log[a0+2]; check("t2_w2", 64'(w.d), 64'h1B1A1918);

    // Test 3: partial word on flush, then a flush with nothing pending.
    a0 = acc_log.size();
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) step();
    check("t3_no_early_word", 64'(acc_log.size() - a0), 64'd0);
    flush = 1'b1;
    step();
    wait_idle("t3_drain", 100);
    check("t3_words", 64'(acc_log.size() - a0), 64'd1);
    w = acc_log[a0];
    check("t3_data", 64'(w.d), 64'h00A3A2A1);
    check("t3_keep", 64'(w.k), 64'h7);
    a0 = acc_log.size();
    flush = 1'b1;
    repeat (6) step();
    check("t3_empty_flush", 64'(acc_log.size() - a0), 64'd0);
    check("t3_busy", {63'd0, busy}, 64'd0);

    // Test 4: flush in the same cycle as the 4th lane read.
    a0 = acc_log.size();
    n = 0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en) begin
        n++;
        if (n == 4) flush = 1'b1;
      end
      step();
    end
    wait_idle("t4_drain", 100);
    repeat (4) step();
    check("t4_words", 64'(acc_log.size() - a0), 64'd1);
    w = acc_log[a0];
    check("t4_data", 64'(w.d), 64'hD4D3D2D1);
    check("t4_keep", 64'(w.k), 64'hF);
    check("t4_busy", {63'd0, busy}, 64'd0);

    // Test 5: reset with a word held and a partial pack.
    out_ready = 1'b0;
    for (int v = 0; v < 6; v++) push(8'(8'hE1 + v));
    repeat (10) step();
    check("t5_pre_valid", {63'd0, out_valid}, 64'd1);
    check("t5_pre_busy", {63'd0, busy}, 64'd1);
    PresetFull = 1'b1;
    #1;
    check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    check("t5_rst_keep", 64'(out_keep), 64'd0);
    check("t5_rst_count", 64'(word_count), 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    fifo_mem.delete();
    fifo_empty = 1'b1;
    step();
    step();
    PresetFull = 1'b0;
    out_ready  = 1'b1;
    a0 = acc_log.size();
    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    wait_idle("t5_drain", 100);
    w = acc_log[a0];
    check("t5_data", 64'(w.d), 64'hF4F3F2F1);
    check("t5_keep", 64'(w.k), 64'hF);
    check("t5_count", 64'(word_count), 64'd1);

    // Test 6: random empty gating and backpressure over 1000 entries.
    a0 = acc_log.size();
    pushed = 0;
    for (int c = 0; c < 8000 && pushed < 1000; c++) begin
      step();
      empty_gate = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      n = $urandom_range(0, 2);
      for (int k = 0; k < n && pushed < 1000; k++) begin
        fifo_mem.push_back(8'(pushed * 7 + 3));
        pushed++;
      end
      fifo_empty = (fifo_mem.size() == 0) || empty_gate;
    end
    wait_idle("t6_drain", 5000);
    check("t6_words", 64'(acc_log.size() - a0), 64'd250);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
